test_window_sequencer: RTL
==========================

# test_window_sequencer

Campaign controller for the FPGA test fixture. It steps the clock-mux setting (CLK_CTL) through up to four frequencies. For each setting it clears the error counters (LS_CNT, SHIFTER_TESTER), opens a timed exposure window with the RO counters gated on, snapshots the results, then waits for the Raspberry Pi to finish reading them before moving on. It sits between the RPi control pins and CLK_GEN_TOP / counter / output blocks, replacing the fixed CLK_CTL tie-off and the raw reset_pi-driven clearing.

## Interface
Parameters:
- WIN_W, 32: width of exposure-window length and counter.
- HOLD_CYC, 16: cycles of cnt_rst per setting (also covers clock-mux settling); legal range 1..255.

Ports:
- CLK  in  1  system clock (clk_50m_sys domain).
- RST  in  1  reset; synchronous, active-high; one clock domain only.
- start  in  1  begin campaign; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- win_len  in  WIN_W  exposure length in CLK cycles; captured on accepted start.
- cfg_mask  in  4  bit i enables CLK_CTL setting i; captured on accepted start.
- host_ack  in  1  host finished reading snapshot; honoured only in WAIT.
- CLK_CTL  out  2  clock-mux select to CLK_GEN_TOP.
- cnt_rst  out  1  clear for error/RO counters.
- read_data  out  1  RO counter gate; high during window only.
- save_data  out  1  single-cycle snapshot strobe to DFF/SHIFTER output blocks.
- snap_valid  out  1  snapshot ready, awaiting host_ack.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at campaign end.

## Operation
- States:
  - IDLE → SETUP, or DONE if the captured cfg_mask is 0.
  - SETUP: cnt_rst high, CLK_CTL = current index, HOLD_CYC cycles → RUN.
  - RUN: read_data high, window counter counts down from win_len → SNAP.
  - SNAP: save_data high for one cycle → WAIT.
  - WAIT: snap_valid high until host_ack → NEXT.
  - NEXT: one cycle; next enabled index above current → SETUP, none → DONE.
  - DONE: done pulse, one cycle → IDLE.
- Index selection: the first setting is the lowest set bit of cfg_mask; indices ascend; there is no wrap-around.
- win_len = 0 is treated as 1.
- The window counter is WIN_W bits, loaded on RUN entry, and leaves RUN when it reaches 1.
- start while busy: ignored. host_ack outside WAIT: ignored, not latched.
- abort: wins over start and host_ack in the same cycle. Next cycle is IDLE with all outputs at reset values, except cnt_rst high for exactly one cycle. No done pulse on abort.
- RST mid-campaign: identical to abort, but without the cnt_rst cycle.
- Reset values: CLK_CTL=00, cnt_rst=0, read_data=0, save_data=0, snap_valid=0, busy=0, done=0. Index and captured registers are 0.
- CLK_CTL holds its last setting in WAIT, NEXT, DONE and IDLE. It changes only on SETUP entry and on reset/abort (→00).
- All outputs are registered and decoded from state; there are no combinational input-to-output paths.

## Timing
- Accepted start at edge t:
  - busy=1, SETUP, CLK_CTL valid and cnt_rst=1 from t+1 through t+HOLD_CYC.
  - read_data=1 from t+HOLD_CYC+1 for exactly max(win_len,1) cycles.
- save_data: high in the single cycle after the last read_data cycle.
- snap_valid: rises the cycle after save_data and falls the cycle after host_ack is sampled.
- NEXT lasts one cycle. Inter-setting gap from the host_ack edge to cnt_rst rise is 2 cycles.
- done: high one cycle after the NEXT cycle that finds no further index. busy falls with done.
- Empty mask: start at t → done=1 at t+1, busy=1 only at t+1, and no cnt_rst, read_data or save_data activity.

## Structure
- Package test_seq_pkg holds:
  - the state enum (IDLE, SETUP, RUN, SNAP, WAIT, NEXT, DONE);
  - the CLK_CTL encoding constants;
  - the default HOLD_CYC.
- Sub-module window_counter: a WIN_W down-counter with load, enable and an at-one flag. It is reused for the HOLD_CYC timer via an 8-bit instance.
- The next-enabled-index finder is a small priority function in the package.

## Test plan
- cfg_mask=0101, win_len=100, HOLD_CYC=16, host_ack 5 cycles after each snap_valid → CLK_CTL 00 then 10; read_data exactly 100 cycles twice; two save_data pulses; done once; busy stays high throughout.
- cfg_mask=0000, start → done at t+1, no cnt_rst, read_data or save_data activity, back to IDLE at t+2.
- win_len=0, cfg_mask=1000 → CLK_CTL=11, read_data high 1 cycle, save_data on the next cycle.
- abort asserted mid-RUN with start high in the same cycle → IDLE next cycle, cnt_rst one cycle, no save_data or done; a later start restarts from the lowest enabled index.
- host_ack pulsed in RUN and in SNAP, then held low → ignored, snap_valid stays high; ack after 1000 cycles advances correctly.
- RST asserted during WAIT → all outputs at reset values on the next cycle, CLK_CTL=00, and a start in the following cycle is accepted.

Source files
------------

// File: rtl/test_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : test_seq_pkg
// Purpose  : Shared types, constants and index finder for the test-window
//            campaign sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package test_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        SNAP  = 3'd3,
        WAIT  = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } seq_state_t;

    localparam logic [1:0] c_CLK_CTL_F0 = 2'b00;
    localparam logic [1:0] c_CLK_CTL_F1 = 2'b01;
    localparam logic [1:0] c_CLK_CTL_F2 = 2'b10;
    localparam logic [1:0] c_CLK_CTL_F3 = 2'b11;

    localparam int c_HOLD_CYC_DEFAULT = 16;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } idx_sel_t;

    // Lowest enabled setting at or above lo; lo = 4 always yields "none".
    function automatic idx_sel_t find_enabled(input logic [3:0] mask, input logic [2:0] lo);
        idx_sel_t r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= lo)) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] clk_ctl_of(input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            2'd0:    r = c_CLK_CTL_F0;
            2'd1:    r = c_CLK_CTL_F1;
            2'd2:    r = c_CLK_CTL_F2;
            default: r = c_CLK_CTL_F3;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_counter.sv
`default_nettype none
// ============================================================================
// Module   : window_counter
// Purpose  : Loadable down-counter with enable and an at-one terminal flag.
// Revision : 1.0 - initial release
// ============================================================================
module window_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_at_one
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_at_one = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/test_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : test_window_sequencer
// Purpose  : Steps CLK_CTL through the enabled settings, running a counter
//            clear, a timed exposure window and a host-acknowledged snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module test_window_sequencer #(
    parameter int WIN_W    = 32,
    parameter int HOLD_CYC = test_seq_pkg::c_HOLD_CYC_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [3:0]       cfg_mask,
    input  logic             host_ack,
    output logic [1:0]       CLK_CTL,
    output logic             cnt_rst,
    output logic             read_data,
    output logic             save_data,
    output logic             snap_valid,
    output logic             busy,
    output logic             done
);

    import test_seq_pkg::*;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [3:0]       r_mask;
    logic [WIN_W-1:0] r_win_len;
    idx_sel_t         w_sel;
    logic             w_hold_one;
    logic             w_win_one;

    // Both timers reload continuously outside their own state, so they hold
    // the full count on the first cycle of SETUP / RUN.
    window_counter #(.WIDTH(8)) u_hold_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (r_state != SETUP),
        .i_en       (r_state == SETUP),
        .i_load_val (8'(HOLD_CYC)),
        .o_at_one   (w_hold_one)
    );

    window_counter #(.WIDTH(WIN_W)) u_win_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (r_state != RUN),
        .i_en       (r_state == RUN),
        .i_load_val (r_win_len),
        .o_at_one   (w_win_one)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sel       = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sel       = find_enabled(cfg_mask, 3'd0);
                    w_idx_nxt   = w_sel.idx;
                    w_state_nxt = w_sel.found ? SETUP : DONE;
                end
            end
            SETUP:   if (w_hold_one) w_state_nxt = RUN;
            RUN:     if (w_win_one)  w_state_nxt = SNAP;
            SNAP:    w_state_nxt = WAIT;
            WAIT:    if (host_ack)   w_state_nxt = NEXT;
            NEXT: begin
                w_sel = find_enabled(r_mask, {1'b0, r_idx} + 3'd1);
                if (w_sel.found) begin
                    w_idx_nxt   = w_sel.idx;
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end
    end

    // Outputs are registered and decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_mask     <= '0;
            r_win_len  <= '0;
            CLK_CTL    <= c_CLK_CTL_F0;
            cnt_rst    <= 1'b0;
            read_data  <= 1'b0;
            save_data  <= 1'b0;
            snap_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (abort) begin
                r_mask    <= '0;
                r_win_len <= '0;
            end else if ((r_state == IDLE) && start) begin
                r_mask    <= cfg_mask;
                r_win_len <= (win_len == '0) ? WIN_W'(1) : win_len;
            end
            if (abort) begin
                CLK_CTL <= c_CLK_CTL_F0;
            end else if (w_state_nxt == SETUP) begin
                CLK_CTL <= clk_ctl_of(w_idx_nxt);
            end
            cnt_rst    <= abort || (w_state_nxt == SETUP);
            read_data  <= (w_state_nxt == RUN);
            save_data  <= (w_state_nxt == SNAP);
            snap_valid <= (w_state_nxt == WAIT);
            busy       <= (w_state_nxt != IDLE);
            done       <= (w_state_nxt == DONE);
        end
    end

endmodule
`default_nettype wire
